// File: rtl/register_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_param
//  Description : Parametrised register bank of 2**ADDR_W words of WIDTH bits.
//                One byte-masked write port, two independent read ports,
//                per-entry valid flags, synchronous bulk clear and a
//                write-to-read bypass for the registered read configuration.
//  Ports       : clk, reset (sync, active-high), clear (sync bulk clear)
//                wr_en / wr_addr / wr_data / wr_mask      write port
//                rd_en_a / rd_addr_a -> rd_data_a, rd_valid_a   read port A
//                rd_en_b / rd_addr_b -> rd_data_b, rd_valid_b   read port B
//                valid_map (per-entry valid flags), full (all entries valid)
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_param #(
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = 3,
    parameter bit READ_REG = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [WIDTH/8-1:0]      wr_mask,
    input  logic                    rd_en_a,
    input  logic [ADDR_W-1:0]       rd_addr_a,
    output logic [WIDTH-1:0]        rd_data_a,
    output logic                    rd_valid_a,
    input  logic                    rd_en_b,
    input  logic [ADDR_W-1:0]       rd_addr_b,
    output logic [WIDTH-1:0]        rd_data_b,
    output logic                    rd_valid_b,
    output logic [(2**ADDR_W)-1:0]  valid_map,
    output logic                    full
);

    localparam int c_DEPTH = 2**ADDR_W;
    localparam int c_BYTES = WIDTH/8;

    logic [WIDTH-1:0]   r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_valid;
    logic               r_full;

    logic [WIDTH-1:0]   w_bitmask;
    logic [WIDTH-1:0]   w_merged;
    logic [c_DEPTH-1:0] w_valid_next;

    // Expand byte enables to a bit mask.
    always_comb begin
        w_bitmask = '0;
        for (int i = 0; i < c_BYTES; i++) begin
            w_bitmask[8*i +: 8] = {8{wr_mask[i]}};
        end
    end

    // Post-write word: new bytes where enabled, stored bytes elsewhere.
    // Invalid entries always hold zero, so a partial write to a fresh entry
    // never exposes stale data.
    assign w_merged = (r_mem[wr_addr] & ~w_bitmask) | (wr_data & w_bitmask);

    // A write marks its entry valid even with an all-zero mask.
    always_comb begin
        w_valid_next = r_valid;
        if (clear) begin
            w_valid_next = '0;
        end else if (wr_en) begin
            w_valid_next[wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid <= '0;
            r_full  <= 1'b0;
        end else begin
            if (clear) begin
                for (int i = 0; i < c_DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
            end else if (wr_en) begin
                r_mem[wr_addr] <= w_merged;
            end
            r_valid <= w_valid_next;
            r_full  <= &w_valid_next;
        end
    end

    assign valid_map = r_valid;
    assign full      = r_full;

    // Read ports gathered into arrays so both share one implementation.
    logic [ADDR_W-1:0] w_rd_addr  [2];
    logic              w_rd_en    [2];
    logic [WIDTH-1:0]  w_rd_data  [2];
    logic              w_rd_valid [2];

    assign w_rd_addr[0] = rd_addr_a;
    assign w_rd_addr[1] = rd_addr_b;
    assign w_rd_en[0]   = rd_en_a;
    assign w_rd_en[1]   = rd_en_b;

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic             w_entry_valid;
        logic [WIDTH-1:0] w_entry;

        assign w_entry_valid = r_valid[w_rd_addr[p]];
        assign w_entry       = w_entry_valid ? r_mem[w_rd_addr[p]] : '0;

        if (READ_REG) begin : g_reg
            logic             w_bypass;
            logic [WIDTH-1:0] r_data;
            logic             r_vld;

            // A clear in the same cycle drops the write, so no bypass then;
            // the read returns the pre-clear contents instead.
            assign w_bypass = wr_en && !clear && (wr_addr == w_rd_addr[p]);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_data <= '0;
                    r_vld  <= 1'b0;
                end else if (w_rd_en[p]) begin
                    if (w_bypass) begin
                        r_data <= w_merged;
                        r_vld  <= 1'b1;
                    end else begin
                        r_data <= w_entry;
                        r_vld  <= w_entry_valid;
                    end
                end
            end

            assign w_rd_data[p]  = r_data;
            assign w_rd_valid[p] = r_vld;
        end else begin : g_comb
            // Strobe has no meaning for a combinational read.
            logic w_unused_rd_en;
            assign w_unused_rd_en = w_rd_en[p];

            assign w_rd_data[p]  = w_entry;
            assign w_rd_valid[p] = w_entry_valid;
        end
    end

    assign rd_data_a  = w_rd_data[0];
    assign rd_valid_a = w_rd_valid[0];
    assign rd_data_b  = w_rd_data[1];
    assign rd_valid_b = w_rd_valid[1];

endmodule
`default_nettype wire

// File: tb/tb_register_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_param
//  Description : Scoreboard bench for register_file_param. Stimulus queues
//                expected responses tagged with the cycle/phase at which they
//                must appear; a monitor process compares them against the
//                registered-read instance and a combinational-read instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_param;

    logic        clk = 1'b0;
    logic        reset, clear, wr_en;
    logic [2:0]  wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_mask;
    logic        rd_en_a, rd_en_b;
    logic [2:0]  rd_addr_a, rd_addr_b;

    logic [63:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic [7:0]  valid_map;
    logic        full;

    logic [63:0] c_rd_data_a, c_rd_data_b;
    logic        c_rd_valid_a, c_rd_valid_b;
    logic [7:0]  c_valid_map;
    logic        c_full;

    always #5 clk = ~clk;

    register_file_param #(.WIDTH(64), .ADDR_W(3), .READ_REG(1'b1)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
        .valid_map(valid_map), .full(full)
    );

    register_file_param #(.WIDTH(64), .ADDR_W(3), .READ_REG(1'b0)) dut_comb (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(c_rd_data_a), .rd_valid_a(c_rd_valid_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(c_rd_data_b), .rd_valid_b(c_rd_valid_b),
        .valid_map(c_valid_map), .full(c_full)
    );

    // kind: 0 = port A, 1 = port B, 2 = valid_map/full, 3 = comb port A
    // ph  : 0 = just after rising edge, 1 = mid-cycle (after inputs change)
    typedef struct {
        int          cyc;
        int          ph;
        int          kind;
        logic [63:0] data;
        logic        valid;
        logic [7:0]  vmap;
        logic        full;
        string       name;
    } chk_t;

    chk_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic exp_rd(input int kind, input logic [63:0] d, input logic v, input string nm);
        chk_t c;
        c.cyc = cyc + 1; c.ph = 0; c.kind = kind;
        c.data = d; c.valid = v; c.vmap = '0; c.full = 1'b0; c.name = nm;
        q.push_back(c);
    endtask

    task automatic exp_st(input logic [7:0] vm, input logic f, input string nm);
        chk_t c;
        c.cyc = cyc + 1; c.ph = 0; c.kind = 2;
        c.data = '0; c.valid = 1'b0; c.vmap = vm; c.full = f; c.name = nm;
        q.push_back(c);
    endtask

    task automatic exp_comb(input logic [63:0] d, input logic v, input string nm);
        chk_t c;
        c.cyc = cyc; c.ph = 1; c.kind = 3;
        c.data = d; c.valid = v; c.vmap = '0; c.full = 1'b0; c.name = nm;
        q.push_back(c);
    endtask

    task automatic compare(input chk_t c);
        logic [63:0] gd;
        logic        gv;
        n_checks++;
        if (c.kind == 2) begin
            if (valid_map !== c.vmap || full !== c.full) begin
                n_fail++;
                $display("FAIL %s: valid_map=%h full=%b, expected valid_map=%h full=%b",
                         c.name, valid_map, full, c.vmap, c.full);
            end
        end else begin
            case (c.kind)
                0:       begin gd = rd_data_a;   gv = rd_valid_a;   end
                1:       begin gd = rd_data_b;   gv = rd_valid_b;   end
                default: begin gd = c_rd_data_a; gv = c_rd_valid_a; end
            endcase
            if (gd !== c.data || gv !== c.valid) begin
                n_fail++;
                $display("FAIL %s: data=%h valid=%b, expected data=%h valid=%b",
                         c.name, gd, gv, c.data, c.valid);
            end
        end
    endtask

    task automatic run_checks(input int ph);
        int i = 0;
        while (i < q.size()) begin
            if (q[i].cyc == cyc && q[i].ph == ph) begin
                compare(q[i]);
                q.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    // Monitor: decoupled from stimulus, driven purely by clock phases.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1 run_checks(0);
            @(negedge clk);
            #2 run_checks(1);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 1'b0; clear = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_en_a = 1'b0; rd_en_b = 1'b0;
    endtask

    int          f_addr [7] = '{0, 1, 3, 4, 5, 6, 7};
    logic [63:0] f_data [7] = '{64'h1010101010101010, 64'h1111111111111111,
                                64'h3333333333333333, 64'h4444444444444444,
                                64'h5555555555555555, 64'hDEADBEEFDEADBEEF,
                                64'h7777777777777777};
    logic [7:0]  f_mask [7] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    logic [7:0]  f_vmap [7] = '{8'h05, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

    initial begin
        idle();
        rd_addr_a = '0; rd_addr_b = '0;

        // Power-up reset
        reset = 1'b1; step();
        reset = 1'b1; exp_st(8'h00, 1'b0, "reset_status"); step();

        // Some writes, then a 2-cycle reset with a write and read in flight
        idle(); wr_en = 1'b1; wr_addr = 3'd0; wr_data = 64'h1234; wr_mask = 8'hFF;
        exp_st(8'h01, 1'b0, "pre_reset_wr0"); step();
        idle(); wr_en = 1'b1; wr_addr = 3'd3; wr_data = 64'h5678; wr_mask = 8'hFF;
        exp_st(8'h09, 1'b0, "pre_reset_wr3"); step();
        idle(); reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 64'h9999; wr_mask = 8'hFF;
        rd_en_a = 1'b1; rd_addr_a = 3'd0;
        exp_rd(0, 64'h0, 1'b0, "reset_rd_a"); exp_st(8'h00, 1'b0, "reset_clears_map"); step();
        idle(); reset = 1'b1;
        exp_rd(0, 64'h0, 1'b0, "reset_rd_a_2"); exp_st(8'h00, 1'b0, "reset_full0"); step();
        idle(); rd_en_a = 1'b1; rd_addr_a = 3'd0; rd_en_b = 1'b1; rd_addr_b = 3'd4;
        exp_rd(0, 64'h0, 1'b0, "post_reset_addr0"); exp_rd(1, 64'h0, 1'b0, "reset_drops_wr4"); step();

        // Full-word write then registered read
        idle(); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 64'h0123456789ABCDEF; wr_mask = 8'hFF;
        exp_st(8'h04, 1'b0, "wr2_status"); step();
        idle(); rd_en_a = 1'b1; rd_addr_a = 3'd2;
        exp_rd(0, 64'h0123456789ABCDEF, 1'b1, "rd2_a"); step();

        // Masked write with same-cycle read on port B (bypass)
        idle(); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 64'hFFFFFFFFFFFFFFFF; wr_mask = 8'h0F;
        rd_en_b = 1'b1; rd_addr_b = 3'd2;
        exp_rd(1, 64'h01234567FFFFFFFF, 1'b1, "bypass_b"); step();
        idle(); rd_en_a = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd0;
        exp_rd(0, 64'h01234567FFFFFFFF, 1'b1, "merged_mem_a");
        exp_rd(1, 64'h01234567FFFFFFFF, 1'b1, "hold_b"); step();

        // Fill remaining entries; addr 6 written with an empty mask
        for (int k = 0; k < 7; k++) begin
            idle(); wr_en = 1'b1; wr_addr = 3'(f_addr[k]); wr_data = f_data[k]; wr_mask = f_mask[k];
            exp_st(f_vmap[k], (k == 6), "fill_status"); step();
        end
        idle(); rd_en_a = 1'b1; rd_addr_a = 3'd6; rd_en_b = 1'b1; rd_addr_b = 3'd7;
        exp_rd(0, 64'h0, 1'b1, "mask0_entry"); exp_rd(1, 64'h7777777777777777, 1'b1, "rd7_b");
        exp_st(8'hFF, 1'b1, "full_before_clear"); step();

        // Clear together with a write to addr 5; reads see pre-clear contents
        idle(); clear = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 64'h9999999999999999; wr_mask = 8'hFF;
        rd_en_a = 1'b1; rd_addr_a = 3'd5; rd_en_b = 1'b1; rd_addr_b = 3'd0;
        exp_rd(0, 64'h5555555555555555, 1'b1, "clear_cycle_rd_a");
        exp_rd(1, 64'h1010101010101010, 1'b1, "clear_cycle_rd_b");
        exp_st(8'h00, 1'b0, "after_clear"); step();
        idle(); rd_en_a = 1'b1; rd_addr_a = 3'd5; rd_en_b = 1'b1; rd_addr_b = 3'd2;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 64'h3333333333333333; wr_mask = 8'hFF;
        exp_rd(0, 64'h0, 1'b0, "clear_drops_wr5"); exp_rd(1, 64'h0, 1'b0, "clear_zeroes_2");
        exp_st(8'h08, 1'b0, "post_clear_wr3"); step();

        // Both ports on one entry, then unwritten addr 7 with rd_en 1,0,0
        idle(); rd_en_a = 1'b1; rd_addr_a = 3'd3; rd_en_b = 1'b1; rd_addr_b = 3'd3;
        exp_rd(0, 64'h3333333333333333, 1'b1, "dual_a"); exp_rd(1, 64'h3333333333333333, 1'b1, "dual_b"); step();
        idle(); rd_en_a = 1'b1; rd_addr_a = 3'd7; rd_en_b = 1'b1; rd_addr_b = 3'd7;
        exp_rd(0, 64'h0, 1'b0, "unwritten_a"); exp_rd(1, 64'h0, 1'b0, "unwritten_b"); step();
        for (int k = 0; k < 2; k++) begin
            idle(); rd_addr_a = 3'd3; rd_addr_b = 3'd3;
            exp_rd(0, 64'h0, 1'b0, "hold_a_en0"); exp_rd(1, 64'h0, 1'b0, "hold_b_en0"); step();
        end

        // Combinational read: address change reflected before the next edge
        idle(); rd_addr_a = 3'd0; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 64'hA5; wr_mask = 8'h01;
        exp_comb(64'h0, 1'b0, "comb_addr0"); step();
        idle(); rd_addr_a = 3'd1;
        exp_comb(64'hA5, 1'b1, "comb_addr1"); step();

        idle(); step(); step();

        foreach (q[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no comparison made, expected at cycle %0d", q[i].name, q[i].cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
